keccak_sponge_ctrl: RTL

// - Upstream sponge controller for the keccak permutation core.
// - Absorbs a 32-bit little-endian message stream into the rate part of a 1600-bit state.
// - Applies SHA-3 multi-rate padding and starts one permutation per rate block.
// - Squeezes the digest as a 32-bit output stream.
// - State word k maps to state bits [32k+31:32k], the same word/bit mapping the keccak register file uses.

---
 rtl/keccak_sponge_pkg.sv | 36 +++
 rtl/keccak_sponge_pad.sv | 38 +++
 rtl/keccak_sponge_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/keccak_sponge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keccak_sponge_pkg
// Description : Shared types and constants for the keccak sponge controller:
//               FSM state enum, state/word widths, pad end byte, and the
//               message byte-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package keccak_sponge_pkg;

  localparam int         STATE_W = 1600;
  localparam int         WORD_W  = 32;
  localparam logic [7:0] PAD_END = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ABSORB  = 3'd1,
    ST_PAD     = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_SQUEEZE = 3'd5
  } sponge_state_e;

  // Keep the low nbytes bytes of a little-endian word and zero the rest.
  function automatic logic [WORD_W-1:0] byte_mask(input logic [WORD_W-1:0] word,
                                                  input logic [2:0]        nbytes);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(nbytes)) m[8*b +: 8] = 8'hFF;
    end
    return word & m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_sponge_pad.sv
`default_nettype none
// ============================================================================
// Module      : keccak_sponge_pad
// Description : Combinational generator of the 32-bit word XORed into one
//               rate word of the sponge state. Masks message bytes beyond
//               msg_bytes, optionally inserts the domain-separation byte at
//               byte lane pos, and the pad end byte at lane 3 when this word
//               is the last rate word.
// Ports       : word        in  32  raw message word
//               msg_bytes   in  3   valid message bytes in word (0..4)
//               pos         in  2   byte lane of the domain-separation byte
//               pad_en      in  1   insert the domain-separation byte
//               final_block in  1   word is the last rate word (pad end)
//               xor_word    out 32  value to XOR into the state word
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_sponge_pad
  import keccak_sponge_pkg::*;
#(
  parameter logic [7:0] DSBYTE = 8'h06
) (
  input  logic [WORD_W-1:0] word,
  input  logic [2:0]        msg_bytes,
  input  logic [1:0]        pos,
  input  logic              pad_en,
  input  logic              final_block,
  output logic [WORD_W-1:0] xor_word
);

  always_comb begin
    xor_word = byte_mask(word, msg_bytes);
    if (pad_en)      xor_word[{pos, 3'b000} +: 8] = xor_word[{pos, 3'b000} +: 8] ^ DSBYTE;
    // Both bytes may land on lane 3 of the same word; XOR keeps both bits.
    if (final_block) xor_word[31:24] = xor_word[31:24] ^ PAD_END;
  end

endmodule
`default_nettype wire

// File: rtl/keccak_sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keccak_sponge_ctrl
// Description : Sponge controller in front of a keccak-f[1600] core. Absorbs
//               a 32-bit little-endian message stream into the rate, applies
//               multi-rate padding, starts one permutation per rate block and
//               squeezes OUT_WORDS digest words. State word k lives in bits
//               [32k+31:32k].
// Ports       : clk_i/rst_i                       clock, sync active-high reset
//               msg_data_i/bytes_i/last_i/valid_i message stream in
//               msg_ready_o                       message accept
//               perm_start_o/din_o                core start pulse and state
//               perm_dout_i/done_i                core result and done pulse
//               dig_data_o/valid_o/last_o         digest stream out
//               dig_ready_i                       digest accept
//               busy_o                            high outside IDLE
//               perm_cnt_o (optional)             permutations this message
// Config      : KECCAK_SPONGE_PERMCNT_EN adds the perm_cnt_o counter port.
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_sponge_ctrl
  import keccak_sponge_pkg::*;
#(
  parameter int         RATE_WORDS = 34,
  parameter int         OUT_WORDS  = 8,
  parameter logic [7:0] DSBYTE     = 8'h06
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WORD_W-1:0]  msg_data_i,
  input  logic [2:0]         msg_bytes_i,
  input  logic               msg_last_i,
  input  logic               msg_valid_i,
  output logic               msg_ready_o,
  output logic               perm_start_o,
  output logic [STATE_W-1:0] perm_din_o,
  input  logic [STATE_W-1:0] perm_dout_i,
  input  logic               perm_done_i,
  output logic [WORD_W-1:0]  dig_data_o,
  output logic               dig_valid_o,
  output logic               dig_last_o,
  input  logic               dig_ready_i,
  output logic               busy_o
`ifdef KECCAK_SPONGE_PERMCNT_EN
  ,
  output logic [15:0]        perm_cnt_o
`endif
);

  localparam logic [7:0] RATE_BYTES    = 8'(RATE_WORDS * 4);
  localparam logic [5:0] LAST_RATE_IDX = 6'(RATE_WORDS - 1);
  localparam logic [5:0] LAST_OUT_IDX  = 6'(OUT_WORDS - 1);

  sponge_state_e      fsm;
  logic [STATE_W-1:0] state;
  logic [5:0]         idx;
  logic [7:0]         pad_pos;
  logic               pad_pend;
  logic               final_blk;

  logic [7:0]         last_pos;
  logic [5:0]         pad_word;
  logic               pad_on_end;
  logic               in_pad;
  logic [WORD_W-1:0]  xor_word;

  assign last_pos   = {idx, 2'b00} + {5'b00000, msg_bytes_i};
  assign pad_word   = pad_pos[7:2];
  assign pad_on_end = (pad_word == LAST_RATE_IDX);
  assign in_pad     = (fsm == ST_PAD);

  // One generator serves both absorb (masked message) and pad (DS/end bytes).
  keccak_sponge_pad #(.DSBYTE(DSBYTE)) u_pad (
    .word        (in_pad ? '0 : msg_data_i),
    .msg_bytes   (in_pad ? 3'd0 : msg_bytes_i),
    .pos         (pad_pos[1:0]),
    .pad_en      (in_pad),
    .final_block (in_pad & pad_on_end),
    .xor_word    (xor_word)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm       <= ST_IDLE;
      state     <= '0;
      idx       <= '0;
      pad_pos   <= '0;
      pad_pend  <= 1'b0;
      final_blk <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE, ST_ABSORB: begin
          if (msg_valid_i) begin
            state[{idx, 5'b0} +: WORD_W] <= state[{idx, 5'b0} +: WORD_W] ^ xor_word;
            if (msg_last_i) begin
              idx <= '0;
              if (last_pos < RATE_BYTES) begin
                pad_pos <= last_pos;
                fsm     <= ST_PAD;
              end else begin
                // Rate exactly filled: padding goes into an extra block.
                pad_pend <= 1'b1;
                pad_pos  <= '0;
                fsm      <= ST_START;
              end
            end else if (idx == LAST_RATE_IDX) begin
              idx <= '0;
              fsm <= ST_START;
            end else begin
              idx <= idx + 6'd1;
              fsm <= ST_ABSORB;
            end
          end
        end
        ST_PAD: begin
          state[{pad_word, 5'b0} +: WORD_W] <= state[{pad_word, 5'b0} +: WORD_W] ^ xor_word;
          if (!pad_on_end) begin
            state[{LAST_RATE_IDX, 5'b0} +: WORD_W] <=
              state[{LAST_RATE_IDX, 5'b0} +: WORD_W] ^ {PAD_END, 24'h000000};
          end
          final_blk <= 1'b1;
          fsm       <= ST_START;
        end
        ST_START: fsm <= ST_WAIT;
        ST_WAIT: begin
          if (perm_done_i) begin
            state <= perm_dout_i;
            if (pad_pend) begin
              pad_pend <= 1'b0;
              pad_pos  <= '0;
              fsm      <= ST_PAD;
            end else if (final_blk) begin
              idx <= '0;
              fsm <= ST_SQUEEZE;
            end else begin
              fsm <= ST_ABSORB;
            end
          end
        end
        ST_SQUEEZE: begin
          if (dig_ready_i) begin
            if (idx == LAST_OUT_IDX) begin
              fsm       <= ST_IDLE;
              state     <= '0;
              idx       <= '0;
              final_blk <= 1'b0;
            end else begin
              idx <= idx + 6'd1;
            end
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; ready is also held low in reset.
  assign msg_ready_o  = ~rst_i & ((fsm == ST_IDLE) | (fsm == ST_ABSORB));
  assign perm_start_o = (fsm == ST_START);
  assign perm_din_o   = state;
  assign dig_valid_o  = (fsm == ST_SQUEEZE);
  assign dig_data_o   = dig_valid_o ? state[{idx, 5'b0} +: WORD_W] : '0;
  assign dig_last_o   = dig_valid_o & (idx == LAST_OUT_IDX);
  assign busy_o       = (fsm != ST_IDLE);

`ifdef KECCAK_SPONGE_PERMCNT_EN
  logic [15:0] perm_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perm_cnt <= '0;
    end else if (fsm == ST_IDLE && msg_valid_i) begin
      perm_cnt <= '0;
    end else if (fsm == ST_START && perm_cnt != 16'hFFFF) begin
      perm_cnt <= perm_cnt + 16'd1;
    end
  end

  assign perm_cnt_o = perm_cnt;
`endif

endmodule
`default_nettype wire
